// File: rtl/fpu_mult_arb_pkg.sv
// Shared types and constants for the two-requester FPU multiplier arbiter.
package fpu_mult_arb_pkg;

  localparam int NREQ = 2;

  localparam logic [1:0] RM_NEAREST = 2'b00;
  localparam logic [1:0] RM_ZERO    = 2'b01;
  localparam logic [1:0] RM_UP      = 2'b10;
  localparam logic [1:0] RM_DOWN    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_ACK   = 3'd4,
    S_RESP  = 3'd5
  } arb_state_t;

  function automatic logic [NREQ-1:0] idx_to_onehot(input logic idx);
    return {idx, ~idx};
  endfunction

endpackage

// File: rtl/fpu_mult_arbiter_if.sv
// Requester-side request/response bus; master = requesters, slave = arbiter.
interface fpu_mult_arbiter_if
  import fpu_mult_arb_pkg::*;
#(
  parameter int W = 32
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_mx;
  logic [NREQ*W-1:0] req_my;
  logic [NREQ*2-1:0] req_rmode;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ack;
  logic [W-1:0]      rsp_result;
  logic              rsp_ovf;
  logic              rsp_unf;
  logic              rsp_err;

  modport master (
    output req_valid, req_mx, req_my, req_rmode, rsp_ack,
    input  req_ready, rsp_valid, rsp_result, rsp_ovf, rsp_unf, rsp_err
  );

  modport slave (
    input  req_valid, req_mx, req_my, req_rmode, rsp_ack,
    output req_ready, rsp_valid, rsp_result, rsp_ovf, rsp_unf, rsp_err
  );
endinterface

// File: rtl/fpu_rr_arbiter.sv
// Two-way round-robin grant; the last-served requester loses ties, requester 0 wins after reset.
module fpu_rr_arbiter
  import fpu_mult_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            update,
  output logic [NREQ-1:0] grant,
  output logic            idx
);
  logic r_last;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = r_last ? 2'b01 : 2'b10;
  end

  assign idx = grant[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_last <= 1'b1;
    else if (update) r_last <= idx;
  end
endmodule

// File: rtl/fpu_mult_arbiter.sv
// Shares one FPU multiplier between two requesters via a LOAD/START/WAIT/ACK/RESP sequence.
// Optional watchdog on WAIT/ACK enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_mult_arbiter
  import fpu_mult_arb_pkg::*;
#(
  parameter int W       = 32,
  parameter int TIMEOUT = 255
)(
  input  logic                  clk,
  input  logic                  rst,
  fpu_mult_arbiter_if.slave     bus,
  output logic                  fpu_beg,
  output logic                  fpu_ack,
  output logic [W-1:0]          fpu_mx,
  output logic [W-1:0]          fpu_my,
  output logic [1:0]            fpu_rmode,
  input  logic                  fpu_ready,
  input  logic                  fpu_ovf,
  input  logic                  fpu_unf,
  input  logic [W-1:0]          fpu_result
);
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  logic [W-1:0] w_mx    [NREQ];
  logic [W-1:0] w_my    [NREQ];
  logic [1:0]   w_rmode [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_mx[gi]    = bus.req_mx[gi*W +: W];
    assign w_my[gi]    = bus.req_my[gi*W +: W];
    assign w_rmode[gi] = bus.req_rmode[gi*2 +: 2];
  end

  arb_state_t      r_state;
  logic            r_gnt_idx;
  logic            r_fpu_beg, r_fpu_ack;
  logic [W-1:0]    r_fpu_mx, r_fpu_my;
  logic [1:0]      r_fpu_rmode;
  logic [NREQ-1:0] r_rsp_valid;
  logic [W-1:0]    r_rsp_result;
  logic            r_rsp_ovf, r_rsp_unf;

  logic [NREQ-1:0] w_gnt_oh;
  logic            w_gnt_idx;
  logic            w_take;

  assign w_take = (r_state == S_IDLE) && (|bus.req_valid);

  fpu_rr_arbiter u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req_valid),
    .update (w_take),
    .grant  (w_gnt_oh),
    .idx    (w_gnt_idx)
  );

  // Grant is visible in the IDLE cycle itself so a new request can win right after rsp_ack.
  assign bus.req_ready = (r_state == S_IDLE && !rst) ? w_gnt_oh : '0;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] r_cnt;
  logic             r_rsp_err;
  logic             w_expired;
  assign w_expired   = (r_state == S_WAIT || r_state == S_ACK) && (r_cnt == TMO_W'(TIMEOUT - 1));
  assign bus.rsp_err = r_rsp_err;
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_gnt_idx    <= 1'b0;
      r_fpu_beg    <= 1'b0;
      r_fpu_ack    <= 1'b0;
      r_fpu_mx     <= '0;
      r_fpu_my     <= '0;
      r_fpu_rmode  <= '0;
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_rsp_ovf    <= 1'b0;
      r_rsp_unf    <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
      r_cnt        <= '0;
      r_rsp_err    <= 1'b0;
`endif
    end else begin
`ifdef FPU_ARB_TIMEOUT_EN
      r_cnt <= (r_state == S_WAIT || r_state == S_ACK) ? r_cnt + TMO_W'(1) : '0;
`endif
      case (r_state)
        S_IDLE: if (|bus.req_valid) begin
          r_gnt_idx   <= w_gnt_idx;
          r_fpu_mx    <= w_mx[w_gnt_idx];
          r_fpu_my    <= w_my[w_gnt_idx];
          r_fpu_rmode <= w_rmode[w_gnt_idx];
`ifdef FPU_ARB_TIMEOUT_EN
          r_rsp_err   <= 1'b0;
`endif
          r_state     <= S_LOAD;
        end
        S_LOAD: begin
          r_fpu_beg <= 1'b1;
          r_state   <= S_START;
        end
        S_START: begin
          r_fpu_beg <= 1'b0;
          r_state   <= S_WAIT;
        end
        S_WAIT: if (fpu_ready) begin
          r_rsp_result <= fpu_result;
          r_rsp_ovf    <= fpu_ovf;
          r_rsp_unf    <= fpu_unf;
          r_fpu_ack    <= 1'b1;
`ifdef FPU_ARB_TIMEOUT_EN
          r_cnt        <= '0;
`endif
          r_state      <= S_ACK;
        end
        S_ACK: if (!fpu_ready) begin
          r_fpu_ack   <= 1'b0;
          r_rsp_valid <= idx_to_onehot(r_gnt_idx);
          r_state     <= S_RESP;
        end
        S_RESP: if (bus.rsp_ack[r_gnt_idx]) begin
          r_rsp_valid <= '0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef FPU_ARB_TIMEOUT_EN
      // Watchdog overrides whatever WAIT/ACK decided this cycle.
      if (w_expired) begin
        r_fpu_ack    <= 1'b0;
        r_rsp_valid  <= idx_to_onehot(r_gnt_idx);
        r_rsp_result <= '0;
        r_rsp_ovf    <= 1'b0;
        r_rsp_unf    <= 1'b0;
        r_rsp_err    <= 1'b1;
        r_cnt        <= '0;
        r_state      <= S_RESP;
      end
`endif
    end
  end

  assign fpu_beg        = r_fpu_beg;
  assign fpu_ack        = r_fpu_ack;
  assign fpu_mx         = r_fpu_mx;
  assign fpu_my         = r_fpu_my;
  assign fpu_rmode      = r_fpu_rmode;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_ovf    = r_rsp_ovf;
  assign bus.rsp_unf    = r_rsp_unf;
endmodule

// File: tb/tb_fpu_mult_arbiter.sv
// Directed bench for fpu_mult_arbiter with a one-cycle multiplier stub; timeout case runs when FPU_ARB_TIMEOUT_EN is defined.
module tb_fpu_mult_arbiter;
  import fpu_mult_arb_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_mult_arbiter_if #(.W(W)) bus ();

  logic         fpu_beg, fpu_ack, fpu_ready, fpu_ovf, fpu_unf;
  logic [W-1:0] fpu_mx, fpu_my, fpu_result;
  logic [1:0]   fpu_rmode;

  fpu_mult_arbiter #(.W(W), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fpu_beg    (fpu_beg),
    .fpu_ack    (fpu_ack),
    .fpu_mx     (fpu_mx),
    .fpu_my     (fpu_my),
    .fpu_rmode  (fpu_rmode),
    .fpu_ready  (fpu_ready),
    .fpu_ovf    (fpu_ovf),
    .fpu_unf    (fpu_unf),
    .fpu_result (fpu_result)
  );

  // Multiplier stub: result one cycle after fpu_beg, ready drops as soon as fpu_ack is seen.
  logic stub_dead;
  logic r_stub_ready, r_stub_ovf, r_stub_unf;
  logic [W-1:0] r_stub_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stub_ready <= 1'b0;
      r_stub_res   <= '0;
      r_stub_ovf   <= 1'b0;
      r_stub_unf   <= 1'b0;
    end else if (fpu_beg && !stub_dead) begin
      r_stub_ready <= 1'b1;
      r_stub_ovf   <= 1'b0;
      r_stub_unf   <= 1'b0;
      if (fpu_mx == 32'h4000_0000 && fpu_my == 32'h4040_0000) r_stub_res <= 32'h40C0_0000;
      else if (fpu_mx == 32'h7F00_0000 && fpu_my == 32'h7F00_0000) begin
        r_stub_res <= 32'h7F80_0000;
        r_stub_ovf <= 1'b1;
      end else if (fpu_mx == 32'h0080_0000 && fpu_my == 32'h0080_0000) begin
        r_stub_res <= 32'h0000_0000;
        r_stub_unf <= 1'b1;
      end else r_stub_res <= fpu_mx ^ fpu_my;
    end else if (fpu_ack) begin
      r_stub_ready <= 1'b0;
    end
  end

  assign fpu_ready  = r_stub_ready & ~fpu_ack;
  assign fpu_result = r_stub_res;
  assign fpu_ovf    = r_stub_ovf;
  assign fpu_unf    = r_stub_unf;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int n, input logic [31:0] mx, input logic [31:0] my, input logic [1:0] rm);
    bus.req_mx[n*W +: W]  = mx;
    bus.req_my[n*W +: W]  = my;
    bus.req_rmode[n*2 +: 2] = rm;
  endtask

  task automatic wait_ready(output logic [1:0] gnt, output int waited);
    waited = 0;
    #1;
    while (bus.req_ready == 2'b00 && waited < 100) begin
      @(negedge clk); #1;
      waited++;
    end
    gnt = bus.req_ready;
    if (gnt == 2'b00) check("req_ready_seen", {63'd0, |gnt}, 64'd1);
  endtask

  // Counts cycles from the req_ready cycle; checks operand stability and a single fpu_beg pulse.
  task automatic wait_rsp(input logic [31:0] exp_mx, input logic [1:0] exp_rm, output int lat);
    bit bad = 1'b0;
    int n_beg = 0;
    lat = 0;
    do begin
      @(negedge clk); #1;
      lat++;
      if (bus.rsp_valid == 2'b00) begin
        if (fpu_mx !== exp_mx || fpu_rmode !== exp_rm) bad = 1'b1;
        if (fpu_beg) n_beg++;
      end
    end while (bus.rsp_valid == 2'b00 && lat < 100);
    if (bus.rsp_valid == 2'b00) check("rsp_valid_seen", {62'd0, bus.rsp_valid}, 64'd1);
    check("operand_stable", {63'd0, bad}, 64'd0);
    check("beg_pulses", 64'(n_beg), 64'd1);
  endtask

  task automatic ack_rsp(input int n);
    bus.rsp_ack[n] = 1'b1;
    @(negedge clk); #1;
    bus.rsp_ack[n] = 1'b0;
    check("rsp_clear", {62'd0, bus.rsp_valid}, 64'd0);
  endtask

  task automatic show(input int n, input int lat);
    $display("txn req%0d valid=%b result=%h ovf=%b unf=%b err=%b lat=%0d",
             n, bus.rsp_valid, bus.rsp_result, bus.rsp_ovf, bus.rsp_unf, bus.rsp_err, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  gnt, eg;
    logic [31:0] er;
    int          waited, lat;
    bit          bad;

    rst = 1'b1;
    stub_dead = 1'b0;
    bus.req_valid = '0;
    bus.req_mx = '0;
    bus.req_my = '0;
    bus.req_rmode = '0;
    bus.rsp_ack = '0;
    repeat (3) @(negedge clk);
    bus.req_valid = 2'b11;
    #1;
    check("rst_req_ready", {62'd0, bus.req_ready}, 64'd0);
    check("rst_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
    check("rst_beg_ack", {62'd0, fpu_beg, fpu_ack}, 64'd0);
    check("rst_fpu_ops", {fpu_mx, fpu_my}, 64'd0);
    check("rst_result", {29'd0, bus.rsp_result, bus.rsp_ovf, bus.rsp_unf, bus.rsp_err}, 64'd0);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Contention: both held, grants must alternate starting at requester 0.
    set_req(0, 32'h4000_0000, 32'h4040_0000, RM_NEAREST);
    set_req(1, 32'h7F00_0000, 32'h7F00_0000, RM_ZERO);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      wait_ready(gnt, waited);
      check($sformatf("cont_grant%0d", k), {62'd0, gnt}, {62'd0, eg});
      if (k > 0) check($sformatf("cont_b2b%0d", k), 64'(waited), 64'd0);
      wait_rsp((k % 2 == 0) ? 32'h4000_0000 : 32'h7F00_0000, (k % 2 == 0) ? RM_NEAREST : RM_ZERO, lat);
      show(k % 2, lat);
      if (k == 0) check("min_latency", 64'(lat), 64'd5);
      er = (k % 2 == 0) ? 32'h40C0_0000 : 32'h7F80_0000;
      check($sformatf("cont_valid%0d", k), {62'd0, bus.rsp_valid}, {62'd0, eg});
      check($sformatf("cont_result%0d", k), {32'd0, bus.rsp_result}, {32'd0, er});
      check($sformatf("cont_ovf%0d", k), {63'd0, bus.rsp_ovf}, {63'd0, eg[1]});
      ack_rsp(k % 2);
    end
    bus.req_valid = '0;
    repeat (2) @(negedge clk);

    // Single request 2.0 * 3.0 plus an ack on the wrong bit that must be ignored.
    set_req(0, 32'h4000_0000, 32'h4040_0000, RM_NEAREST);
    bus.req_valid = 2'b01;
    wait_ready(gnt, waited);
    check("single_grant", {62'd0, gnt}, 64'd1);
    wait_rsp(32'h4000_0000, RM_NEAREST, lat);
    show(0, lat);
    bus.req_valid = '0;
    check("single_valid", {62'd0, bus.rsp_valid}, 64'd1);
    check("single_result", {32'd0, bus.rsp_result}, 64'h40C0_0000);
    check("single_flags", {61'd0, bus.rsp_ovf, bus.rsp_unf, bus.rsp_err}, 64'd0);
    bus.rsp_ack = 2'b10;
    @(negedge clk); #1;
    bus.rsp_ack = 2'b00;
    check("wrong_ack_ignored", {62'd0, bus.rsp_valid}, 64'd1);
    ack_rsp(0);

    // Overflow on requester 1 with 20 cycles of backpressure while requester 0 waits.
    set_req(1, 32'h7F00_0000, 32'h7F00_0000, RM_UP);
    bus.req_valid = 2'b10;
    wait_ready(gnt, waited);
    check("ovf_grant", {62'd0, gnt}, 64'd2);
    wait_rsp(32'h7F00_0000, RM_UP, lat);
    show(1, lat);
    check("ovf_valid", {62'd0, bus.rsp_valid}, 64'd2);
    check("ovf_flag", {62'd0, bus.rsp_ovf, bus.rsp_unf}, 64'd2);
    set_req(0, 32'h0080_0000, 32'h0080_0000, RM_DOWN);
    bus.req_valid = 2'b01;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid !== 2'b10 || bus.rsp_result !== 32'h7F80_0000 || bus.req_ready !== 2'b00) bad = 1'b1;
    end
    check("bp_hold", {63'd0, bad}, 64'd0);
    ack_rsp(1);
    check("bp_regrant", {62'd0, bus.req_ready}, 64'd1);
    wait_rsp(32'h0080_0000, RM_DOWN, lat);
    show(0, lat);
    bus.req_valid = '0;
    check("unf_latency", 64'(lat), 64'd5);
    check("unf_valid", {62'd0, bus.rsp_valid}, 64'd1);
    check("unf_result", {31'd0, bus.rsp_result, bus.rsp_unf}, 64'd1);
    ack_rsp(0);

    // Reset while waiting on the multiplier.
    stub_dead = 1'b1;
    set_req(0, 32'h4000_0000, 32'h4040_0000, RM_NEAREST);
    bus.req_valid = 2'b01;
    wait_ready(gnt, waited);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_outputs", {60'd0, bus.req_ready, bus.rsp_valid}, 64'd0);
    check("midrst_fpu_ops", {fpu_mx, fpu_my}, 64'd0);
    check("midrst_beg_ack", {62'd0, fpu_beg, fpu_ack}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    stub_dead = 1'b0;
    set_req(1, 32'h7F00_0000, 32'h7F00_0000, RM_ZERO);
    bus.req_valid = 2'b11;
    wait_ready(gnt, waited);
    check("post_rst_grant", {62'd0, gnt}, 64'd1);
    wait_rsp(32'h4000_0000, RM_NEAREST, lat);
    show(0, lat);
    check("post_rst_result", {30'd0, bus.rsp_valid, bus.rsp_result}, {30'd1, 32'h40C0_0000});
    ack_rsp(0);
    bus.req_valid = '0;

`ifdef FPU_ARB_TIMEOUT_EN
    // Stalled multiplier: watchdog fires 8 cycles after WAIT entry (WAIT entered 3 cycles after grant).
    repeat (2) @(negedge clk);
    stub_dead = 1'b1;
    bus.req_valid = 2'b10;
    wait_ready(gnt, waited);
    wait_rsp(32'h7F00_0000, RM_ZERO, lat);
    show(1, lat);
    bus.req_valid = '0;
    check("tmo_latency", 64'(lat), 64'd11);
    check("tmo_err", {62'd0, bus.rsp_valid, bus.rsp_err}, {62'd0, 2'b10, 1'b1} >> 0);
    check("tmo_result", {32'd0, bus.rsp_result}, 64'd0);
    ack_rsp(1);
    stub_dead = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fpu_mult_arbiter.md
FPU_MULT_ARBITER -- requirements
Module: fpu_mult_arbiter

Interface
REQ-001 Parameter W, default 32, IEEE-754 word width (32 or 64).
REQ-002 Parameter TIMEOUT, default 255, watchdog limit in cycles (used only when FPU_ARB_TIMEOUT_EN is defined).
REQ-003 clk  in  1  sole clock; all logic SHALL be on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid  in  2  per-requester operation request; bit n belongs to requester n.
REQ-006 req_ready  out  2  per-requester request accepted this cycle; one-hot or zero.
REQ-007 req_mx, req_my  in  2*W  operands; slice [n*W +: W] belongs to requester n.
REQ-008 req_rmode  in  4  rounding modes; slice [n*2 +: 2] belongs to requester n.
REQ-009 rsp_valid  out  2  per-requester result valid, one-hot or zero.
REQ-010 rsp_ack  in  2  per-requester result consumed.
REQ-011 rsp_result  out  W  shared result bus; qualified by rsp_valid.
REQ-012 rsp_ovf, rsp_unf, rsp_err  out  1 each  flags qualified by rsp_valid.
REQ-013 fpu_beg, fpu_ack  out  1 each  drive the multiplier FSM start and acknowledge inputs.
REQ-014 fpu_mx, fpu_my  out  W each; fpu_rmode  out  2.  Registered operand and mode drive.
REQ-015 fpu_ready, fpu_ovf, fpu_unf  in  1 each; fpu_result  in  W.  Multiplier status and result.

Function
REQ-016 FSM states: IDLE, LOAD, START, WAIT, ACK, RESP.
REQ-017 IDLE: if any req_valid is set, grant via round-robin; req_ready[g]=1 for one cycle; latch operands, rmode, and grant index; go to LOAD.
REQ-018 Round-robin: the last-served requester has lowest priority; after reset, requester 0 has priority.
REQ-019 LOAD: drive the latched operands, fpu_beg=0, for one cycle; go to START.
REQ-020 START: fpu_beg=1 for exactly one cycle; go to WAIT.
REQ-021 WAIT: on fpu_ready=1, capture fpu_result, fpu_ovf, and fpu_unf; go to ACK.
REQ-022 ACK: hold fpu_ack=1 until fpu_ready=0 is sampled, then go to RESP; fpu_ack SHALL deassert in the same cycle.
REQ-023 RESP: hold rsp_valid[g]=1 and a stable result until rsp_ack[g]=1, then go to IDLE.
REQ-024 rsp_ack on a non-granted bit, or while rsp_valid is low, SHALL be ignored.
REQ-025 Requests arriving outside IDLE SHALL NOT be accepted; they wait, because req_valid is held by the requester.
REQ-026 Simultaneous req_valid=2'b11 in IDLE SHALL grant the priority holder only.
REQ-027 fpu_mx, fpu_my, and fpu_rmode SHALL remain stable from LOAD through ACK.
REQ-028 Minimum latency, from the req_ready cycle to the first rsp_valid cycle, SHALL be 4 cycles plus the multiplier latency.
REQ-029 A new grant SHALL be possible in the cycle after rsp_ack (back-to-back).

Reset
REQ-030 On rst: state=IDLE; all outputs 0 (req_ready, rsp_valid, fpu_beg, fpu_ack, fpu_mx, fpu_my, fpu_rmode, rsp_result, and all rsp flags); priority=requester 0.
REQ-031 Reset mid-operation SHALL abandon the operation with no response; fpu_beg and fpu_ack SHALL drop asynchronously.

Configuration
REQ-032 Macro FPU_ARB_TIMEOUT_EN defined: a cycle counter SHALL run in WAIT and in ACK.
REQ-033 If that counter reaches TIMEOUT, the FSM SHALL go to RESP with rsp_err=1 and rsp_result=0.
REQ-034 The counter SHALL clear on every state entry.
REQ-035 Macro FPU_ARB_TIMEOUT_EN undefined: no counter SHALL be present, rsp_err SHALL be tied 0, and WAIT SHALL be unbounded.

Structure
REQ-036 Package fpu_mult_arb_pkg SHALL hold the state enum typedef, the requester-count constant (2), and the rounding-mode constants.
REQ-037 Sub-module fpu_rr_arbiter SHALL provide the 2-way round-robin grant: inputs req and update, outputs one-hot grant and index.

Verification
REQ-038 Single request: req0, mx=0x40000000 (2.0), my=0x40400000 (3.0), rmode=00 -> rsp_valid=2'b01, rsp_result=0x40C00000, ovf=unf=0.
REQ-039 Contention: req_valid=2'b11 held after reset -> grants in order 0,1,0,1; no result is delivered to the wrong requester.
REQ-040 Overflow: mx=my=0x7F000000 -> rsp_ovf=1, with rsp_valid held until rsp_ack.
REQ-041 Backpressure: rsp_ack held low for 20 cycles -> rsp_result stable and no new req_ready during that time; grant occurs 1 cycle after the ack.
REQ-042 Reset in WAIT: assert rst -> outputs 0 immediately; the next request after release completes correctly.
REQ-043 With FPU_ARB_TIMEOUT_EN and TIMEOUT=8, fpu_ready stubbed low -> rsp_err=1 exactly 8 cycles after WAIT entry.
